i2s_tdm_clkgen: RTL and testbench
=================================

// Module: i2s_tdm_clkgen
// PURPOSE
//   Parametrised I2S/TDM bit- and frame-clock generator for the audio front end.
//   Divides clk by a runtime-programmable ratio to make BCLK. Frames BCLK into SLOTS slots of SLOT_BITS bits.
//   Drives LRCLK as either a 50%-duty I2S word clock or a one-BCLK DSP/TDM frame-sync pulse.
//   Exports slot/bit indices and edge strobes so serialisers need no counters of their own.
// PARAMETERS
//   DIV_WIDTH  8   width of div_half; BCLK half-period in clk cycles, range 1..2^DIV_WIDTH-1
//   SLOT_BITS  32  BCLKs per slot (>=2)
//   SLOTS      2   slots per frame (>=2; must be even when fs_mode=0)
// PORTS
//   clk           in   1                     system clock; one clock domain
//   rst           in   1                     reset; synchronous and active-high
//   enable        in   1                     run request
//   div_half      in   DIV_WIDTH             BCLK half-period in clk cycles; 0 is treated as 1
//   fs_mode       in   1                     0 = I2S 50% LRCLK, 1 = one-BCLK frame-sync pulse
//   bclk          out  1                     bit clock, idles low
//   lrclk         out  1                     word clock / frame sync
//   bclk_rising   out  1                     1-cycle strobe in the cycle before bclk goes 0->1
//   bclk_falling  out  1                     1-cycle strobe in the cycle before bclk goes 1->0
//   frame_start   out  1                     1-cycle strobe: next BCLK period is slot 0, bit 0
//   slot_idx      out  max(1,$clog2(SLOTS))  current slot
//   bit_idx       out  $clog2(SLOT_BITS)     current bit within slot (0 = MSB)
//   busy          out  1                     high in RUN and STOPPING
// BEHAVIOUR
//   Reset:
//     - All outputs are 0; FSM goes to IDLE; the divider latch div_q is set to 1.
//     - rst mid-frame produces reset values on the next edge, with no frame completion.
//   FSM IDLE:
//     - Exit on enable=1: div_q <= (div_half==0 ? 1 : div_half); counters clear; frame_start pulses 1 cycle; go to RUN.
//   FSM RUN:
//     - half counter runs 0..div_q-1; at terminal count it wraps and bclk toggles.
//     - bclk_rising = terminal & ~bclk; bclk_falling = terminal & bclk.
//     - BCLK period is 2*div_q clk cycles.
//   Index counters:
//     - On bclk_falling, bit_idx increments.
//     - bit_idx wraps SLOT_BITS-1 -> 0 and increments slot_idx.
//     - slot_idx wraps SLOTS-1 -> 0; that is the frame wrap.
//   Frame wrap:
//     - frame_start pulses with the wrapping bclk_falling.
//     - div_q reloads from div_half only here and at IDLE exit; mid-frame div_half changes are ignored.
//   LRCLK (registered on bclk_falling, from the next indices):
//     - fs_mode=0: lrclk = (slot_idx_next >= SLOTS/2).
//     - fs_mode=1: lrclk = (slot_idx_next==0 && bit_idx_next==0), i.e. high for exactly 1 BCLK per frame.
//     - fs_mode is sampled only at frame wrap; it is constant within a frame.
//   FSM STOPPING:
//     - enable=0 in RUN goes to STOPPING; clocks keep running to the end of the current frame.
//     - At frame wrap: go to IDLE; bclk, lrclk, slot_idx and bit_idx return to 0; busy falls; no frame_start.
//     - enable=1 during STOPPING returns to RUN with no gap, and no extra frame_start beyond the normal wrap pulse.
//   Simultaneous events: enable=1 in RUN is a no-op; rst has priority over everything.
// CONFIGURATION
//   I2S_TDM_CLKGEN_FRAMECNT_EN:
//     - Defined: adds output frame_count[15:0]; resets to 0; +1 on every frame_start (including the IDLE-exit
//       pulse); wraps 16'hFFFF -> 0; holds its value in IDLE.
//     - Undefined: no port and no logic.
// TESTING
//   1. SLOTS=2, SLOT_BITS=32, div_half=4, fs_mode=0, enable=1 -> bclk period 8 clk; lrclk flips every 32 falls; frame = 512 clk.
//   2. SLOTS=8, SLOT_BITS=16, fs_mode=1, div_half=2 -> lrclk high for 4 clk every 512 clk; slot_idx steps 0..7.
//   3. div_half 4->2 mid-frame -> period stays 8 clk until frame_start, then becomes 4 clk.
//   4. enable=0 at slot 0 bit 5 -> frame completes; busy=0; bclk=0. Re-enable in STOPPING -> next frame starts with no gap.
//   5. div_half=0 -> behaves as 1; bclk = clk/2; bclk_falling every 2nd cycle.
//   6. rst at slot 1 bit 17 -> all outputs 0 next cycle; with FRAMECNT_EN, frame_count=0; after 3 frames it reads 3.

Source files
------------

// File: rtl/i2s_tdm_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tdm_clkgen
// Brief    : I2S / TDM bit-clock and frame-clock generator. Divides clk by a
//            runtime-programmable ratio to make BCLK, frames BCLK into
//            SLOTS slots of SLOT_BITS bits, and drives LRCLK either as a 50%
//            I2S word clock or as a one-BCLK DSP/TDM frame-sync pulse. Slot
//            and bit indices plus BCLK edge strobes are exported so that
//            serialisers need no counters of their own.
// Options  : `define I2S_TDM_CLKGEN_FRAMECNT_EN adds output frame_count[15:0],
//            a wrapping count of frame_start pulses.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tdm_clkgen #(
    parameter int DIV_WIDTH = 8,
    parameter int SLOT_BITS = 32,
    parameter int SLOTS     = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    input  logic [DIV_WIDTH-1:0]                      div_half,
    input  logic                                      fs_mode,
    output logic                                      bclk,
    output logic                                      lrclk,
    output logic                                      bclk_rising,
    output logic                                      bclk_falling,
    output logic                                      frame_start,
    output logic [((SLOTS > 1) ? $clog2(SLOTS) : 1)-1:0] slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0]              bit_idx,
    output logic                                      busy
`ifdef I2S_TDM_CLKGEN_FRAMECNT_EN
    ,
    output logic [15:0]                               frame_count
`endif
);

    localparam int c_slot_w = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int c_bit_w  = $clog2(SLOT_BITS);

    localparam logic [c_slot_w-1:0]  c_slot_last = c_slot_w'(SLOTS - 1);
    localparam logic [c_slot_w-1:0]  c_slot_half = c_slot_w'(SLOTS / 2);
    localparam logic [c_slot_w-1:0]  c_slot_one  = c_slot_w'(1);
    localparam logic [c_bit_w-1:0]   c_bit_last  = c_bit_w'(SLOT_BITS - 1);
    localparam logic [c_bit_w-1:0]   c_bit_one   = c_bit_w'(1);
    localparam logic [DIV_WIDTH-1:0] c_div_one   = DIV_WIDTH'(1);

    // Controller states
    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_run      = 2'd1;
    localparam logic [1:0] c_st_stopping = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    logic [DIV_WIDTH-1:0] r_div_q;
    logic [DIV_WIDTH-1:0] r_half_cnt;
    logic                 r_bclk;
    logic                 r_lrclk;
    logic                 r_fs_mode;
    logic [c_slot_w-1:0]  r_slot_idx;
    logic [c_bit_w-1:0]   r_bit_idx;

    logic                 w_running;
    logic                 w_terminal;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_bit_last;
    logic                 w_slot_last;
    logic                 w_wrap;
    logic                 w_start_idle;
    logic                 w_wrap_keep;
    logic                 w_stop_done;
    logic                 w_frame_start;
    logic                 w_fs_eff;
    logic                 w_lr_next;
    logic [c_bit_w-1:0]   w_bit_next;
    logic [c_slot_w-1:0]  w_slot_next;
    logic [DIV_WIDTH-1:0] w_div_load;

    // Divider terminal count, index look-ahead and frame-boundary decode
    always_comb begin
        w_running    = (r_state != c_st_idle);
        w_terminal   = w_running && (r_half_cnt == (r_div_q - c_div_one));
        w_rise       = w_terminal && !r_bclk;
        w_fall       = w_terminal && r_bclk;
        w_bit_last   = (r_bit_idx == c_bit_last);
        w_slot_last  = (r_slot_idx == c_slot_last);
        w_wrap       = w_fall && w_bit_last && w_slot_last;
        w_start_idle = (r_state == c_st_idle) && enable;
        // A wrap starts a new frame unless we are stopping and nobody asked to continue
        w_wrap_keep  = w_wrap && ((r_state == c_st_run) || enable);
        w_stop_done  = w_wrap && (r_state == c_st_stopping) && !enable;
        w_div_load   = (div_half == '0) ? c_div_one : div_half;

        w_bit_next   = w_bit_last ? '0 : (r_bit_idx + c_bit_one);
        if (w_bit_last) begin
            w_slot_next = w_slot_last ? '0 : (r_slot_idx + c_slot_one);
        end else begin
            w_slot_next = r_slot_idx;
        end

        // fs_mode only takes effect at a frame boundary
        w_fs_eff = w_wrap_keep ? fs_mode : r_fs_mode;
        if (w_fs_eff) begin
            w_lr_next = (w_slot_next == '0) && (w_bit_next == '0);
        end else begin
            w_lr_next = (w_slot_next >= c_slot_half);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and edge/frame strobes
    always_comb begin
        w_state_next  = r_state;
        bclk_rising   = w_rise;
        bclk_falling  = w_fall;
        w_frame_start = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (enable) begin
                    w_state_next  = c_st_run;
                    w_frame_start = !rst;
                end
            end
            c_st_run: begin
                w_frame_start = w_wrap && !rst;
                if (!enable) begin
                    w_state_next = c_st_stopping;
                end
            end
            c_st_stopping: begin
                w_frame_start = w_wrap_keep && !rst;
                if (enable) begin
                    w_state_next = c_st_run;
                end else if (w_wrap) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Divider, BCLK, index counters and LRCLK
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q    <= c_div_one;
            r_half_cnt <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_fs_mode  <= 1'b0;
            r_slot_idx <= '0;
            r_bit_idx  <= '0;
        end else if (w_start_idle) begin
            // First frame: slot 0 bit 0, so LRCLK is the sync pulse in DSP mode
            // and the left-channel level (low) in I2S mode
            r_div_q    <= w_div_load;
            r_half_cnt <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= fs_mode;
            r_fs_mode  <= fs_mode;
            r_slot_idx <= '0;
            r_bit_idx  <= '0;
        end else if (w_running) begin
            if (w_terminal) begin
                r_half_cnt <= '0;
                r_bclk     <= !r_bclk;
            end else begin
                r_half_cnt <= r_half_cnt + c_div_one;
            end

            if (w_fall) begin
                if (w_stop_done) begin
                    r_slot_idx <= '0;
                    r_bit_idx  <= '0;
                    r_lrclk    <= 1'b0;
                end else begin
                    r_slot_idx <= w_slot_next;
                    r_bit_idx  <= w_bit_next;
                    r_lrclk    <= w_lr_next;
                end
                // Ratio and mode are frame-constant; mid-frame changes wait for the wrap
                if (w_wrap_keep) begin
                    r_div_q   <= w_div_load;
                    r_fs_mode <= fs_mode;
                end
            end
        end
    end

`ifdef I2S_TDM_CLKGEN_FRAMECNT_EN
    logic [15:0] r_frame_count;

    // Frame counter: counts every frame_start, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (w_frame_start) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign frame_start = w_frame_start;
    assign bclk        = r_bclk;
    assign lrclk       = r_lrclk;
    assign slot_idx    = r_slot_idx;
    assign bit_idx     = r_bit_idx;
    assign busy        = w_running;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tdm_clkgen
// Brief    : Scoreboard bench for i2s_tdm_clkgen (SLOTS=8, SLOT_BITS=16).
//            Stimulus pushes expected frame / stop / snapshot records; a
//            negedge monitor pops and compares them as the DUT presents
//            frame_start strobes, busy falls and snapshot requests.
// Options  : honours `define I2S_TDM_CLKGEN_FRAMECNT_EN for frame_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_clkgen;

    localparam int DIV_WIDTH = 8;
    localparam int SLOT_BITS = 16;
    localparam int SLOTS     = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [DIV_WIDTH-1:0] div_half;
    logic                 fs_mode;
    logic                 bclk;
    logic                 lrclk;
    logic                 bclk_rising;
    logic                 bclk_falling;
    logic                 frame_start;
    logic [2:0]           slot_idx;
    logic [3:0]           bit_idx;
    logic                 busy;
`ifdef I2S_TDM_CLKGEN_FRAMECNT_EN
    logic [15:0]          frame_count;
`endif

    i2s_tdm_clkgen #(
        .DIV_WIDTH (DIV_WIDTH),
        .SLOT_BITS (SLOT_BITS),
        .SLOTS     (SLOTS)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .div_half     (div_half),
        .fs_mode      (fs_mode),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .bclk_rising  (bclk_rising),
        .bclk_falling (bclk_falling),
        .frame_start  (frame_start),
        .slot_idx     (slot_idx),
        .bit_idx      (bit_idx),
        .busy         (busy)
`ifdef I2S_TDM_CLKGEN_FRAMECNT_EN
        ,
        .frame_count  (frame_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected record at a frame_start strobe; len/falls/lr < 0 means skip
    typedef struct {
        string name;
        bit    from_idle;
        int    len;
        int    falls;
        int    lr;
    } fexp_t;

    // Expected record at a busy 1->0 transition; len < 0 means skip
    typedef struct {
        string name;
        int    len;
    } sexp_t;

    // Expected output snapshot at the next negedge; fields < 0 are skipped
    typedef struct {
        string name;
        int    bclk;
        int    lrclk;
        int    busy;
        int    slot;
        int    bitv;
        int    fc;
    } snap_t;

    // Stimulus-side observation (timeouts, leftovers) handed to the monitor
    typedef struct {
        string name;
        int    act;
        int    exp;
    } cexp_t;

    fexp_t fq[$];
    sexp_t sq[$];
    snap_t nq[$];
    cexp_t cq[$];

    int    checks = 0;
    int    errors = 0;
    bit    mon_on = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor state
    int    cyc       = 0;
    int    last_fs   = 0;
    int    win_falls = 0;
    int    win_lr    = 0;
    bit    busy_prev = 1'b0;
    fexp_t f_cur;
    sexp_t s_cur;
    snap_t n_cur;
    cexp_t c_cur;

    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            if (bclk_falling) win_falls++;
            if (lrclk)        win_lr++;

            while (cq.size() > 0) begin
                c_cur = cq.pop_front();
                chk(c_cur.name, c_cur.act, c_cur.exp);
            end

            if (nq.size() > 0) begin
                n_cur = nq.pop_front();
                if (n_cur.bclk  >= 0) chk({n_cur.name, ".bclk"},  int'(bclk),     n_cur.bclk);
                if (n_cur.lrclk >= 0) chk({n_cur.name, ".lrclk"}, int'(lrclk),    n_cur.lrclk);
                if (n_cur.busy  >= 0) chk({n_cur.name, ".busy"},  int'(busy),     n_cur.busy);
                if (n_cur.slot  >= 0) chk({n_cur.name, ".slot"},  int'(slot_idx), n_cur.slot);
                if (n_cur.bitv  >= 0) chk({n_cur.name, ".bit"},   int'(bit_idx),  n_cur.bitv);
`ifdef I2S_TDM_CLKGEN_FRAMECNT_EN
                if (n_cur.fc    >= 0) chk({n_cur.name, ".frame_count"}, int'(frame_count), n_cur.fc);
`endif
            end

            if (frame_start) begin
                if (fq.size() == 0) begin
                    chk("unexpected_frame_start", 1, 0);
                end else begin
                    f_cur = fq.pop_front();
                    chk({f_cur.name, ".busy"}, int'(busy),     f_cur.from_idle ? 0 : 1);
                    chk({f_cur.name, ".bclk"}, int'(bclk),     f_cur.from_idle ? 0 : 1);
                    chk({f_cur.name, ".slot"}, int'(slot_idx), f_cur.from_idle ? 0 : SLOTS - 1);
                    chk({f_cur.name, ".bit"},  int'(bit_idx),  f_cur.from_idle ? 0 : SLOT_BITS - 1);
                    if (f_cur.len   >= 0) chk({f_cur.name, ".frame_len"},  cyc - last_fs, f_cur.len);
                    if (f_cur.falls >= 0) chk({f_cur.name, ".falls"},      win_falls,     f_cur.falls);
                    if (f_cur.lr    >= 0) chk({f_cur.name, ".lrclk_high"}, win_lr,        f_cur.lr);
                end
                last_fs   = cyc;
                win_falls = 0;
                win_lr    = 0;
            end

            if (busy_prev && !busy) begin
                if (sq.size() == 0) begin
                    chk("unexpected_busy_fall", 1, 0);
                end else begin
                    s_cur = sq.pop_front();
                    if (s_cur.len >= 0) chk({s_cur.name, ".len"}, cyc - last_fs, s_cur.len);
                    chk({s_cur.name, ".bclk"},        int'(bclk),        0);
                    chk({s_cur.name, ".lrclk"},       int'(lrclk),       0);
                    chk({s_cur.name, ".slot"},        int'(slot_idx),    0);
                    chk({s_cur.name, ".bit"},         int'(bit_idx),     0);
                    chk({s_cur.name, ".frame_start"}, int'(frame_start), 0);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input string n, input bit idle, input int len,
                              input int falls, input int lr);
        fexp_t t;
        t.name = n; t.from_idle = idle; t.len = len; t.falls = falls; t.lr = lr;
        fq.push_back(t);
    endtask

    task automatic push_stop(input string n, input int len);
        sexp_t t;
        t.name = n; t.len = len;
        sq.push_back(t);
    endtask

    task automatic push_snap(input string n, input int b, input int l, input int bz,
                             input int s, input int bi, input int fc);
        snap_t t;
        t.name = n; t.bclk = b; t.lrclk = l; t.busy = bz; t.slot = s; t.bitv = bi; t.fc = fc;
        nq.push_back(t);
    endtask

    task automatic push_obs(input string n, input int act, input int exp);
        cexp_t t;
        t.name = n; t.act = act; t.exp = exp;
        cq.push_back(t);
    endtask

    task automatic wait_fq_empty(input int max_cyc);
        int n = 0;
        while (fq.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (fq.size() != 0) push_obs("timeout_frames_pending", fq.size(), 0);
    endtask

    task automatic wait_fs(input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < max_cyc);
        if (!frame_start) push_obs("timeout_frame_start", 0, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (busy) push_obs("timeout_idle", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        div_half = 8'd4;
        fs_mode  = 1'b0;
        step(3);
        mon_on = 1'b1;
        push_snap("reset", 0, 0, 0, 0, 0, 0);
        step(2);
        rst = 1'b0;
        step(2);

        // I2S, div 4: frame = 8*16 BCLKs * 8 clk = 1024, LRCLK high for slots 4..7
        push_frame("start",       1, -1,   -1,  -1);
        push_frame("i2s_div4_f1", 0, 1024, 128, 512);
        push_frame("i2s_div4_f2", 0, 1024, 128, 512);
        enable = 1'b1;
        wait_fq_empty(4000);

        // Mid-frame ratio and mode change: current frame unchanged, next is TDM div 2
        push_frame("div_hold",    0, 1024, 128, 512);
        push_frame("tdm_div2_f1", 0, 512,  128, 4);
        push_frame("tdm_div2_f2", 0, 512,  128, 4);
        step(100);
        div_half = 8'd2;
        fs_mode  = 1'b1;
        wait_fq_empty(4000);

        // div_half 0 behaves as 1: BCLK = clk/2
        push_frame("tdm_div2_f3", 0, 512, 128, 4);
        push_frame("div0_i2s",    0, 256, 128, 128);
        step(10);
        div_half = 8'd0;
        fs_mode  = 1'b0;
        wait_fq_empty(2000);

        // Stop request near slot 0 bit 5 of a div-4 frame: the frame completes
        push_frame("div0_i2s_b", 0, 256, 128, 128);
        step(1);
        div_half = 8'd4;
        wait_fs(1000);
        step(40);
        push_stop("stop_len", 1025);
        enable = 1'b0;
        wait_idle(3000);
        step(20);
        push_snap("idle_after_stop", 0, 0, 0, 0, 0, 9);

        // Restart, then re-enable while stopping: no gap, normal wrap pulse only
        push_frame("restart", 1, -1, -1, -1);
        enable = 1'b1;
        wait_fs(100);
        step(40);
        push_frame("reenable_f1", 0, 1024, 128, 512);
        push_frame("reenable_f2", 0, 1024, 128, 512);
        enable = 1'b0;
        step(100);
        push_snap("stopping_busy", -1, -1, 1, -1, -1, -1);
        enable = 1'b1;
        wait_fq_empty(4000);

        // Reset mid-frame (around slot 1 bit 7), then three frame_starts
        step(186);
        rst = 1'b1;
        push_stop("rst_mid", -1);
        step(1);
        push_snap("after_rst", 0, 0, 0, 0, 0, 0);
        push_frame("post_rst_start", 1, -1,   -1,  -1);
        push_frame("post_rst_f1",    0, 1024, 128, 512);
        push_frame("post_rst_f2",    0, 1024, 128, 512);
        step(1);
        rst = 1'b0;
        wait_fq_empty(4000);
        step(1);
        push_snap("frame_count3", 0, 0, 1, 0, 0, 3);
        step(5);
        push_stop("final_stop", 1025);
        enable = 1'b0;
        wait_idle(2000);
        step(5);

        push_obs("frames_left", fq.size(), 0);
        push_obs("stops_left",  sq.size(), 0);
        push_obs("snaps_left",  nq.size(), 0);
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
